uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Packet-level round-robin arbiter that shares one UART transmit byte stream between NUM_REQ independent requesters (e.g. debug console, telemetry, rx echo).
- Each requester presents a valid/ready byte stream with a last flag; a grant is held for a whole packet.
- Optionally prefixes each packet with a source-ID header byte.
- Output feeds the uart_tx byte interface (tx_data/tx_vld/tx_rdy).

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_PREFIX, 1, 1 = emit header byte {4'hA, id[3:0]} before each packet; 0 = no header.
- MAX_PKT_LEN, 64, maximum data bytes per grant (header not counted); legal range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_data  in  NUM_REQ*8  byte from requester i at bits [8i+7:8i]
- req_vld  in  NUM_REQ  requester i has a byte
- req_last  in  NUM_REQ  byte on requester i is the final byte of its packet
- req_rdy  out  NUM_REQ  byte on requester i accepted this cycle
- tx_data  out  8  byte to uart_tx
- tx_vld  out  1  tx_data valid
- tx_rdy  in  1  uart_tx accepts byte
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester
- busy  out  1  high while a packet is granted (HDR or DATA state)
- trunc  out  1  one-cycle pulse when a packet is cut at MAX_PKT_LEN

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - All outputs are 0 after reset; state = IDLE.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has top priority first.
  - Byte counter = 0.
- Handshake: a byte transfers on a cycle where tx_vld && tx_rdy.
  - Requesters hold req_data/req_last stable while req_vld && !req_rdy.
  - req_vld must not be withdrawn before acceptance.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - tx_vld = 0; req_rdy = 0.
  - If any req_vld is set, select the first set bit searching from last_grant+1 upward, with wrap-around.
  - Register the selection into grant_id; busy <= 1.
  - Next state is HDR if ID_PREFIX, else DATA.
  - The selection is made in the same cycle req_vld is seen. tx_vld first rises on the following cycle.
- HDR:
  - tx_vld = 1 (registered); tx_data = {4'hA, grant_id padded to 4 bits}; req_rdy = 0.
  - Holds until tx_rdy, then goes to DATA.
- DATA:
  - Combinational passthrough from the granted requester g: tx_vld = req_vld[g], tx_data = req_data[g], req_rdy[g] = tx_rdy.
  - req_rdy of every other requester is 0.
  - The byte counter increments on each accepted byte.
  - A req_vld[g] gap mid-packet drops tx_vld; the grant is held indefinitely.
- End of packet:
  - On an accepted byte with req_last[g] = 1: last_grant <= g; counter <= 0; busy <= 0; go to IDLE.
  - The next arbitration happens in IDLE one cycle later, so there is one idle cycle between packets.
- Truncation:
  - On an accepted byte that brings the counter to MAX_PKT_LEN with req_last[g] = 0: trunc pulses on the next cycle.
  - Otherwise identical to end of packet.
  - The requester's remaining bytes compete as a new packet; with ID_PREFIX = 1 they get a fresh header.
  - If req_last coincides with reaching MAX_PKT_LEN, it is a normal end and trunc = 0.
- Starvation bound: any requester holding req_vld is granted within NUM_REQ-1 packets.
- grant_id retains its last value in IDLE.
- Reset mid-packet: the next cycle returns to IDLE with all req_rdy = 0 and tx_vld = 0, and the round-robin pointer is reinitialised. The in-flight packet is abandoned without trunc.
- Widths: counter is 16 bits. The arbitration search is a rotating priority over NUM_REQ bits.

Test Plan:
- ID_PREFIX=1, req 2 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), tx_rdy=1 → tx stream 0xA2,0x11,0x22,0x33; grant_id=2; busy high for exactly 4 cycles; req_rdy[2] high on the 3 data cycles only.
- Reqs 0 and 1 both hold valid 2-byte packets continuously → packet order 0,1,0,1; headers 0xA0,0xA1 alternate; one idle cycle between packets.
- tx_rdy toggles 1,0,0,1 during DATA → each byte appears on tx_data unchanged until accepted; no byte duplicated or lost; req_rdy mirrors tx_rdy.
- MAX_PKT_LEN=4, req 3 sends 6 bytes with last on byte 6 → trunc pulses once after byte 4. A new header 0xA3 then precedes bytes 5-6 if no other requester is waiting. If req 0 is waiting, req 0's packet is served between them.
- req_vld[1] drops for 5 cycles mid-packet while req 0 is valid → tx_vld=0 during the gap; grant stays on 1; req_rdy[0]=0 throughout.
- rst asserted during DATA of req 2 → next cycle state IDLE, tx_vld=0, all req_rdy=0, busy=0; with reqs 0 and 2 valid after reset, req 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter that merges NUM_REQ byte streams onto one uart_tx byte port.
// Each packet can be preceded by a {4'hA, id} header, and long packets are cut at MAX_PKT_LEN.
module uart_tx_arb #(
  parameter int NUM_REQ     = 4,
  parameter int ID_PREFIX   = 1,
  parameter int MAX_PKT_LEN = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_rdy,
  output logic [7:0]                 tx_data,
  output logic                       tx_vld,
  input  logic                       tx_rdy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       trunc
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t         state_reg;
  logic [IDW-1:0] grant_reg;
  logic [IDW-1:0] last_grant_reg;
  logic [IDW-1:0] sel_next;
  logic [15:0]    cnt_reg;
  logic           busy_reg;
  logic           trunc_reg;

  logic [7:0]     req_byte [NUM_REQ];
  logic           g_vld;
  logic           g_last;
  logic [7:0]     g_data;
  logic           g_accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  assign g_vld    = req_vld[grant_reg];
  assign g_last   = req_last[grant_reg];
  assign g_data   = req_byte[grant_reg];
  assign g_accept = (state_reg == DATA) && g_vld && tx_rdy;

  // Rotating priority: scan offsets from farthest to nearest so last_grant+1 wins.
  always_comb begin
    logic [IDW:0] idx;
    sel_next = last_grant_reg;
    idx      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = {1'b0, last_grant_reg} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
      if (req_vld[idx[IDW-1:0]]) sel_next = idx[IDW-1:0];
    end
  end

  always_comb begin
    req_rdy = '0;
    tx_vld  = 1'b0;
    tx_data = 8'h00;
    case (state_reg)
      HDR: begin
        tx_vld  = 1'b1;
        tx_data = {4'hA, 4'(grant_reg)};
      end
      DATA: begin
        tx_vld             = g_vld;
        tx_data            = g_data;
        req_rdy[grant_reg] = tx_rdy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= IDW'(NUM_REQ - 1);
      cnt_reg        <= '0;
      busy_reg       <= 1'b0;
      trunc_reg      <= 1'b0;
    end else begin
      trunc_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req_vld) begin
            grant_reg <= sel_next;
            busy_reg  <= 1'b1;
            if (ID_PREFIX != 0) state_reg <= HDR;
            else                state_reg <= DATA;
          end
        end
        HDR: begin
          if (tx_rdy) state_reg <= DATA;
        end
        DATA: begin
          if (g_accept) begin
            // A cut packet releases the grant exactly like a normal end.
            if (g_last || (cnt_reg == 16'(MAX_PKT_LEN - 1))) begin
              last_grant_reg <= grant_reg;
              cnt_reg        <= '0;
              busy_reg       <= 1'b0;
              trunc_reg      <= !g_last;
              state_reg      <= IDLE;
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grant_id = grant_reg;
  assign busy     = busy_reg;
  assign trunc    = trunc_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queued requester packets, a packet-level round-robin model,
// directed scenarios plus randomized traffic with random tx_rdy back-pressure.
module tb_uart_tx_arb;

  localparam int NR   = 4;
  localparam int MAXL = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0]   req_vld = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_rdy;
  logic [7:0]      tx_data;
  logic            tx_vld;
  logic            tx_rdy = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;
  logic            trunc;

  always #5 clk = ~clk;

  uart_tx_arb #(.NUM_REQ(NR), .ID_PREFIX(1), .MAX_PKT_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_vld(req_vld), .req_last(req_last),
    .req_rdy(req_rdy), .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .grant_id(grant_id), .busy(busy), .trunc(trunc)
  );

  int tests = 0;
  int fails = 0;

  logic [8:0]    req_q [NR][$];  // {last, data} per requester
  logic [7:0]    exp_q[$];
  logic [7:0]    out_q[$];
  int            exp_trunc;
  int            model_ptr;
  int            model_last_id;
  int            acc_cyc[$];
  int            trunc_cyc[$];
  logic          busy_log[$];
  logic [NR-1:0] rdy_log[$];
  int            pops [NR];
  int            gap_req = -1;
  int            gap_after = 0;
  int            gap_len = 0;
  int            gap_cnt = 0;
  int            gap_seen = 0;

  task automatic add_byte(input int r, input logic [7:0] d, input logic l);
    req_q[r].push_back({l, d});
  endtask

  task automatic add_rand_pkt(input int r, input int len);
    for (int j = 0; j < len; j++) add_byte(r, 8'($urandom), (j == len - 1));
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NR; i++) if (req_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Packet-level model: round robin over non-empty queues, header, then data up to MAXL.
  task automatic build_model();
    logic [8:0] mq [NR][$];
    logic [8:0] b;
    int id;
    int n;
    for (int i = 0; i < NR; i++) mq[i] = req_q[i];
    exp_q.delete();
    exp_trunc = 0;
    forever begin
      id = -1;
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (model_ptr + k) % NR;
        if (id < 0 && mq[c].size() > 0) id = c;
      end
      if (id < 0) break;
      exp_q.push_back(8'hA0 | 8'(id));
      n = 0;
      forever begin
        b = mq[id].pop_front();
        exp_q.push_back(b[7:0]);
        n++;
        if (b[8]) break;
        if (n == MAXL) begin
          exp_trunc++;
          break;
        end
      end
      model_ptr     = id;
      model_last_id = id;
    end
  endtask

  function automatic int stream_err();
    int n;
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (out_q[i] !== exp_q[i]) return i;
    if (out_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [7:0] out_at(input int i);
    return (i < out_q.size()) ? out_q[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 8'hxx;
  endfunction

  task automatic drive_inputs(input bit gap_on);
    logic [8:0] h;
    for (int i = 0; i < NR; i++) begin
      if (req_q[i].size() > 0 && !(gap_on && i == gap_req)) begin
        h = req_q[i][0];
        req_vld[i]          = 1'b1;
        req_data[8*i +: 8]  = h[7:0];
        req_last[i]         = h[8];
      end else begin
        req_vld[i]          = 1'b0;
        req_data[8*i +: 8]  = 8'($urandom);
        req_last[i]         = 1'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req_vld  = '0;
    req_data = '0;
    req_last = '0;
    tx_rdy   = 1'b0;
    for (int i = 0; i < NR; i++) req_q[i].delete();
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    model_ptr = NR - 1;
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 pattern 1,0,0,1. stop_bytes>0 stops early.
  task automatic run_traffic(input int max_cyc, input int rdy_mode, input int stop_bytes);
    int            cyc;
    bit            prev_hold;
    logic [7:0]    prev_data;
    bit            gap_on;
    logic [NR-1:0] want_rdy;
    cyc       = 0;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    out_q.delete(); acc_cyc.delete(); trunc_cyc.delete(); busy_log.delete(); rdy_log.delete();
    for (int i = 0; i < NR; i++) pops[i] = 0;
    gap_cnt  = 0;
    gap_seen = 0;
    forever begin
      if (stop_bytes > 0 && out_q.size() >= stop_bytes) break;
      if (stop_bytes == 0 && cyc > 0 && queues_empty() && !busy) break;
      if (cyc >= max_cyc) begin
        tests++; fails++;
        $display("FAIL timeout: ran %0d cycles, required completion within %0d", cyc, max_cyc);
        break;
      end
      case (rdy_mode)
        0:       tx_rdy = 1'b1;
        1:       tx_rdy = ($urandom_range(0, 3) != 0);
        default: tx_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      gap_on = (gap_req >= 0) && (pops[gap_req] == gap_after) && (gap_cnt < gap_len);
      drive_inputs(gap_on);
      @(negedge clk);
      if (prev_hold) begin
        tests++;
        if (tx_vld !== 1'b1 || tx_data !== prev_data) begin
          fails++;
          $display("FAIL hold: tx_vld=%b tx_data=%02h, required 1/%02h", tx_vld, tx_data, prev_data);
        end
      end
      want_rdy = '0;
      if (busy) want_rdy[grant_id] = tx_rdy;
      tests++;
      if (req_rdy !== '0 && req_rdy !== want_rdy) begin
        fails++;
        $display("FAIL req_rdy: got %b, required 0 or %b", req_rdy, want_rdy);
      end
      if (gap_on) begin
        gap_seen++;
        tests++;
        if (tx_vld !== 1'b0 || int'(grant_id) != gap_req || req_rdy[0] !== 1'b0) begin
          fails++;
          $display("FAIL gap: tx_vld=%b grant_id=%0d req_rdy=%b, required 0/%0d/rdy0=0",
                   tx_vld, grant_id, req_rdy, gap_req);
        end
        gap_cnt++;
      end
      if (tx_vld && tx_rdy) begin
        out_q.push_back(tx_data);
        acc_cyc.push_back(cyc);
      end
      if (trunc) trunc_cyc.push_back(cyc);
      busy_log.push_back(busy);
      rdy_log.push_back(req_rdy);
      for (int i = 0; i < NR; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          void'(req_q[i].pop_front());
          pops[i]++;
        end
      end
      prev_hold = tx_vld && !tx_rdy;
      prev_data = tx_data;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (tx_vld !== 1'b0) begin fails++; $display("FAIL reset tx_vld: got %b, required 0", tx_vld); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset tx_data: got %02h, required 00", tx_data); end
    tests++; if (req_rdy !== '0) begin fails++; $display("FAIL reset req_rdy: got %b, required 0", req_rdy); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b, required 0", busy); end
    tests++; if (trunc !== 1'b0) begin fails++; $display("FAIL reset trunc: got %b, required 0", trunc); end
    tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset grant_id: got %0d, required 0", grant_id); end
  endtask

  task automatic test_single();
    int e, nb, nr, nz;
    do_reset();
    add_byte(2, 8'h11, 1'b0); add_byte(2, 8'h22, 1'b0); add_byte(2, 8'h33, 1'b1);
    build_model();
    run_traffic(100, 0, 0);
    e = stream_err();
    tests++;
    if (e >= 0) begin
      fails++;
      $display("FAIL single stream: idx %0d got %02h want %02h (%0d/%0d bytes)", e, out_at(e), exp_at(e), out_q.size(), exp_q.size());
    end
    nb = 0; nr = 0; nz = 0;
    foreach (busy_log[i]) if (busy_log[i]) nb++;
    foreach (rdy_log[i]) begin
      if (rdy_log[i] == 4'b0100) nr++;
      if (rdy_log[i] != 4'b0000) nz++;
    end
    tests++; if (nb != 4) begin fails++; $display("FAIL single busy cycles: got %0d, required 4", nb); end
    tests++; if (nr != 3 || nz != 3) begin fails++; $display("FAIL single req_rdy cycles: got %0d (nonzero %0d), required 3", nr, nz); end
    tests++; if (grant_id !== 2'd2) begin fails++; $display("FAIL single grant_id: got %0d, required 2", grant_id); end
  endtask

  task automatic test_alternate();
    int e, first, last, idle;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      add_rand_pkt(0, 2);
      add_rand_pkt(1, 2);
    end
    build_model();
    run_traffic(200, 0, 0);
    e = stream_err();
    tests++;
    if (e >= 0) begin
      fails++;
      $display("FAIL alternate stream: idx %0d got %02h want %02h (%0d/%0d bytes)", e, out_at(e), exp_at(e), out_q.size(), exp_q.size());
    end
    first = -1; last = -1; idle = 0;
    foreach (busy_log[i]) if (busy_log[i]) begin if (first < 0) first = i; last = i; end
    for (int i = first; i <= last && first >= 0; i++) if (!busy_log[i]) idle++;
    tests++; if (idle != 3) begin fails++; $display("FAIL alternate idle cycles: got %0d, required 3", idle); end
  endtask

  task automatic test_toggle();
    int e;
    do_reset();
    add_rand_pkt(1, 5);
    build_model();
    run_traffic(200, 2, 0);
    e = stream_err();
    tests++;
    if (e >= 0) begin
      fails++;
      $display("FAIL toggle stream: idx %0d got %02h want %02h (%0d/%0d bytes)", e, out_at(e), exp_at(e), out_q.size(), exp_q.size());
    end
  endtask

  task automatic test_trunc();
    int e;
    do_reset();
    add_rand_pkt(2, 1);
    build_model();
    run_traffic(100, 0, 0);
    add_rand_pkt(3, 6);
    build_model();
    run_traffic(200, 0, 0);
    e = stream_err();
    tests++;
    if (e >= 0) begin
      fails++;
      $display("FAIL trunc stream: idx %0d got %02h want %02h (%0d/%0d bytes)", e, out_at(e), exp_at(e), out_q.size(), exp_q.size());
    end
    tests++;
    if (trunc_cyc.size() != 1 || acc_cyc.size() < 5) begin
      fails++;
      $display("FAIL trunc count: got %0d pulses, required 1", trunc_cyc.size());
    end else if (trunc_cyc[0] != acc_cyc[4] + 1) begin
      fails++;
      $display("FAIL trunc timing: pulse at cycle %0d, required %0d", trunc_cyc[0], acc_cyc[4] + 1);
    end
    // Point the rotation at 2, then let req 0 wait while req 3 is cut.
    add_rand_pkt(2, 1);
    build_model();
    run_traffic(100, 0, 0);
    add_rand_pkt(3, 6);
    add_rand_pkt(0, 2);
    build_model();
    run_traffic(200, 0, 0);
    e = stream_err();
    tests++;
    if (e >= 0) begin
      fails++;
      $display("FAIL trunc interleave stream: idx %0d got %02h want %02h (%0d/%0d bytes)", e, out_at(e), exp_at(e), out_q.size(), exp_q.size());
    end
    tests++;
    if (out_q.size() > 5 && out_q[5] !== 8'hA0) begin
      fails++;
      $display("FAIL trunc interleave header: got %02h, required a0", out_q[5]);
    end
    tests++;
    if (trunc_cyc.size() != exp_trunc) begin
      fails++;
      $display("FAIL trunc interleave count: got %0d, required %0d", trunc_cyc.size(), exp_trunc);
    end
  endtask

  task automatic test_gap();
    int e;
    do_reset();
    add_rand_pkt(0, 2);
    add_rand_pkt(0, 2);
    add_rand_pkt(1, 4);
    build_model();
    gap_req = 1; gap_after = 1; gap_len = 5;
    run_traffic(200, 0, 0);
    gap_req = -1;
    e = stream_err();
    tests++;
    if (e >= 0) begin
      fails++;
      $display("FAIL gap stream: idx %0d got %02h want %02h (%0d/%0d bytes)", e, out_at(e), exp_at(e), out_q.size(), exp_q.size());
    end
    tests++; if (gap_seen != 5) begin fails++; $display("FAIL gap length: got %0d cycles, required 5", gap_seen); end
  endtask

  task automatic test_reset_mid();
    int e;
    do_reset();
    add_rand_pkt(2, 5);
    build_model();
    run_traffic(100, 0, 3);
    drive_inputs(1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++; if (tx_vld !== 1'b0) begin fails++; $display("FAIL rstmid tx_vld: got %b, required 0", tx_vld); end
    tests++; if (req_rdy !== '0) begin fails++; $display("FAIL rstmid req_rdy: got %b, required 0", req_rdy); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid busy: got %b, required 0", busy); end
    tests++; if (trunc !== 1'b0) begin fails++; $display("FAIL rstmid trunc: got %b, required 0", trunc); end
    for (int i = 0; i < NR; i++) req_q[i].delete();
    model_ptr = NR - 1;
    add_rand_pkt(2, 2);
    add_rand_pkt(0, 2);
    build_model();
    run_traffic(100, 0, 0);
    e = stream_err();
    tests++;
    if (e >= 0) begin
      fails++;
      $display("FAIL rstmid stream: idx %0d got %02h want %02h (%0d/%0d bytes)", e, out_at(e), exp_at(e), out_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    int e;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      for (int r = 0; r < NR; r++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) add_rand_pkt(r, $urandom_range(1, 6));
      end
      build_model();
      run_traffic(1000, 1, 0);
      e = stream_err();
      tests++;
      if (e >= 0) begin
        fails++;
        $display("FAIL random[%0d] stream: idx %0d got %02h want %02h (%0d/%0d bytes)", it, e, out_at(e), exp_at(e), out_q.size(), exp_q.size());
      end
      tests++;
      if (trunc_cyc.size() != exp_trunc) begin
        fails++;
        $display("FAIL random[%0d] trunc: got %0d, required %0d", it, trunc_cyc.size(), exp_trunc);
      end
      if (exp_q.size() > 0) begin
        tests++;
        if (int'(grant_id) != model_last_id) begin
          fails++;
          $display("FAIL random[%0d] grant_id: got %0d, required %0d", it, grant_id, model_last_id);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_toggle();
    test_trunc();
    test_gap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1);
  end

endmodule
